// File: rtl/axis_frame_scheduler.sv
// Line/frame sequencer for a line-burst AXI4-Stream source: one line_start per line,
// tracks TLAST handshakes, inserts line/frame gaps, and watches for stalled lines.
module axis_frame_scheduler #(
    parameter int PIXELS_VERTICAL = 1024,
    parameter int LINE_GAP        = 0,
    parameter int FRAME_DELAY     = 2,
    parameter int LINE_TIMEOUT    = 4096
) (
    input  logic        M_AXIS_ACLK,
    input  logic        M_AXIS_ARESETN,
    input  logic        ctrl_enable,
    input  logic        ctrl_oneshot,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast,
    output logic        line_start,
    output logic        sof,
    output logic [11:0] line_index,
    output logic [3:0]  frame_index,
    output logic        frame_done,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int WD_W = (LINE_TIMEOUT > 1) ? $clog2(LINE_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'((LINE_TIMEOUT > 0) ? LINE_TIMEOUT - 1 : 0);
    localparam logic [9:0]      LG_LAST   = 10'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [9:0]      FD_LAST   = 10'((FRAME_DELAY > 0) ? FRAME_DELAY - 1 : 0);
    localparam logic [11:0]     LAST_LINE = 12'(PIXELS_VERTICAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE_START,
        S_LINE_WAIT,
        S_LINE_GAP,
        S_FRAME_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [9:0]      gap_cnt;
    logic [WD_W-1:0] wdog;
    logic            oneshot_q;
    logic            beat, eol;
    logic            frame_go, line_adv, frame_end, wd_fire;

    assign beat = mon_tvalid & mon_tready;
    assign eol  = beat & mon_tlast;

    always_comb begin
        state_nxt = state;
        frame_go  = 1'b0;
        line_adv  = 1'b0;
        frame_end = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            // A completed one-shot frame keeps oneshot_q set, parking here until enable drops.
            S_IDLE: begin
                if (ctrl_enable && !oneshot_q) begin
                    state_nxt = S_LINE_START;
                    frame_go  = 1'b1;
                end
            end
            S_LINE_START: state_nxt = S_LINE_WAIT;
            S_LINE_WAIT: begin
                if (eol) begin
                    if (line_index == LAST_LINE) begin
                        frame_end = 1'b1;
                        if (FRAME_DELAY != 0) begin
                            state_nxt = S_FRAME_GAP;
                        end else if (ctrl_enable && !oneshot_q) begin
                            state_nxt = S_LINE_START;
                            frame_go  = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        line_adv  = 1'b1;
                        state_nxt = (LINE_GAP != 0) ? S_LINE_GAP : S_LINE_START;
                    end
                end else if (LINE_TIMEOUT != 0 && wdog == WD_LAST) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_LINE_GAP: begin
                if (gap_cnt == LG_LAST) state_nxt = S_LINE_START;
            end
            S_FRAME_GAP: begin
                if (gap_cnt == FD_LAST) begin
                    if (ctrl_enable && !oneshot_q) begin
                        state_nxt = S_LINE_START;
                        frame_go  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            wdog        <= '0;
            oneshot_q   <= 1'b0;
            line_start  <= 1'b0;
            sof         <= 1'b0;
            line_index  <= '0;
            frame_index <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_start  <= (state_nxt == S_LINE_START);
            busy        <= (state_nxt != S_IDLE);
            frame_done  <= frame_end;
            err_timeout <= wd_fire;
            err_overrun <= eol && (state != S_LINE_WAIT);

            if ((state == S_LINE_GAP || state == S_FRAME_GAP) && state_nxt == state)
                gap_cnt <= gap_cnt + 10'd1;
            else
                gap_cnt <= '0;

            // Saturating watchdog; cleared every line_start.
            if (state == S_LINE_START)
                wdog <= '0;
            else if (state == S_LINE_WAIT && wdog != '1)
                wdog <= wdog + WD_W'(1);

            if (frame_go)
                oneshot_q <= ctrl_oneshot;
            else if (wd_fire || (state == S_IDLE && !ctrl_enable))
                oneshot_q <= 1'b0;

            if (frame_end || wd_fire || frame_go)
                line_index <= '0;
            else if (line_adv)
                line_index <= line_index + 12'd1;

            if (frame_end)
                frame_index <= frame_index + 4'd1;

            // sof marks the frame's first beat; a new frame start overrides a same-cycle clear.
            if (frame_go)
                sof <= 1'b1;
            else if (wd_fire || (sof && beat && state == S_LINE_WAIT))
                sof <= 1'b0;
        end
    end

endmodule
